alu_multilane: RTL and testbench
================================

Name: alu_multilane

Overview:
- Multi-cycle, parametrised successor to the single-byte 6502 ALU.
- Processes operands of LANES lanes, each DATA_W bits wide, one lane per clock, and chains carry between lanes in a register.
- Supports multi-byte arithmetic, shifts and rotates, INC/DEC and compare, with optional BCD correction.
- Sits beside the byte ALU. The sequencer uses it for 16-bit pointer math and wide ADC/SBC; results and flags return through a start/done handshake.

Parameters:
- DATA_W, 8, lane width in bits; must be a multiple of 4.
- LANES, 2, number of lanes per operation; must be at least 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  one-cycle request; operands latched when sampled high while idle
- op  input  4  operation select
- decimal  input  1  BCD mode for ADC/SBC (D flag)
- carry_in  input  1  incoming C flag
- alu_a  input  DATA_W*LANES  operand A
- alu_b  input  DATA_W*LANES  operand B
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; result and flags valid
- alu_out  output  DATA_W*LANES  result, registered and held until the next done
- flags_out  output  8  {N,V,0,0,0,0,Z,C}, held
- flags_ena  output  8  flag write mask, held; qualified by done

Behaviour:
- Reset: busy=0, done=0, alu_out=0, flags_out=0, flags_ena=0, lane counter=0, carry register=0. Reset asserted mid-operation aborts the operation; no done is issued.
- FSM states:
  - IDLE: start=1 latches op, decimal, carry_in, alu_a and alu_b, then goes to RUN. Busy rises in the cycle after start.
  - RUN: one lane per cycle, lane counter 0..LANES-1. After the last lane, go to DONE.
  - DONE: done=1 for one cycle, outputs update, busy=0, return to IDLE.
- Latency: done asserts exactly LANES+1 cycles after the start cycle.
- start while busy or done is ignored; no queueing.
- Lane order: LSB lane first for every op except LSR and ROR, which go MSB lane first. The inter-lane carry register carries the bit shifted out.
- Opcodes (initial carry shown as cin; mask given as flags_ena):
  - 0 ADD: cin=0; mask NZC.
  - 1 ADC: cin=carry_in; mask NVZC.
  - 2 SBC: A+~B+carry_in; mask NVZC.
  - 3 CMP: A+~B+1; mask NZC.
  - 4 AND, 5 ORA, 6 EOR: mask NZ.
  - 7 ASL: bit0 fill = 0; mask NZC.
  - 8 LSR: MSB fill = 0; mask NZC.
  - 9 ROL: bit0 fill = carry_in; mask NZC.
  - 10 ROR: MSB fill = carry_in; mask NZC.
  - 11 INC: A+1; mask NZ.
  - 12 DEC: A+all-ones; mask NZ.
  - 13-15: alu_out=0, flags_ena=0, done still pulses.
- Flag rules:
  - N = MSB of the full result.
  - Z = full result equals 0, computed across all lanes.
  - C = final carry, or the last bit shifted out for shift/rotate ops.
  - V (ADC/SBC only): (A_msb == B'_msb) and (R_msb != A_msb), where B' = B for ADC and ~B for SBC, taken from the top lane's binary result.
  - Flag bits not in the mask are driven 0.
- Width: all arithmetic is modulo 2^(DATA_W*LANES). Wrap-around is normal, not an error.

Optional Feature:
- Macro: ALU_MULTILANE_DECIMAL_EN.
- Defined: when decimal=1 for ADC/SBC, each 4-bit nibble is BCD-corrected.
  - ADC: add 6 when nibble > 9 or nibble carry.
  - SBC: subtract 6 when nibble borrow.
  - Corrected nibble carries propagate across nibbles and lanes.
  - C, N and Z are taken from the corrected result; V from the binary result.
  - Only valid BCD inputs are defined.
- Undefined: decimal is ignored and all arithmetic is binary.

Test Plan (DATA_W=8, LANES=2):
- ADC 0x12FF+0x0001, carry_in=0 -> alu_out=0x1300, flags N0 V0 Z0 C0, flags_ena=0xC3; done exactly 3 cycles after start.
- SBC 0x0000-0x0001, carry_in=1 -> 0xFFFF, N1 V0 Z0 C0. ADC 0x7FFF+0x0001 -> 0x8000, V1 N1.
- ROR 0x0001, carry_in=1 -> 0x8000, C1 N1. LSR 0x8001 -> 0x4000, C1 N0.
- Decimal (macro on) ADC 0x0999+0x0001, carry_in=0 -> 0x1000, C0. ADC 0x9999+0x0001 -> 0x0000, C1 Z1. Macro off: 0x0999+0x0001 -> 0x099A.
- start pulsed again while busy -> ignored, single done with the first result. rst asserted in the RUN cycle -> busy=0, done=0, alu_out=0; no done follows.
- op=14 -> done pulses, alu_out=0, flags_ena=0. CMP 0x1234 vs 0x1234 -> Z1 C1 N0, flags_ena=0x83.

Source files
------------

// File: rtl/alu_multilane.sv
// Lane-serial multi-byte ALU: one DATA_W lane per clock, carry/shift bit chained in a register.
// Define ALU_MULTILANE_DECIMAL_EN to enable BCD correction for ADC/SBC.
module alu_multilane #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              op,
  input  logic                    decimal,
  input  logic                    carry_in,
  input  logic [DATA_W*LANES-1:0] alu_a,
  input  logic [DATA_W*LANES-1:0] alu_b,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W*LANES-1:0] alu_out,
  output logic [7:0]              flags_out,
  output logic [7:0]              flags_ena
);

  localparam int unsigned WIDTH = DATA_W * LANES;
  localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned NIBS  = DATA_W / 4;

`ifdef ALU_MULTILANE_DECIMAL_EN
  localparam logic DEC_EN = 1'b1;
`else
  localparam logic DEC_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_ADC, OP_SBC, OP_CMP, OP_AND, OP_ORA, OP_EOR, OP_ASL,
    OP_LSR, OP_ROL, OP_ROR, OP_INC, OP_DEC, OP_RSV13, OP_RSV14, OP_RSV15
  } op_t;

  function automatic logic f_init_carry(input op_t f_op, input logic f_cin);
    case (f_op)
      OP_ADC, OP_SBC, OP_ROL, OP_ROR: return f_cin;
      OP_CMP, OP_INC:                 return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] f_mask(input op_t f_op);
    case (f_op)
      OP_ADC, OP_SBC:                                 return 8'hC3;
      OP_ADD, OP_CMP, OP_ASL, OP_LSR, OP_ROL, OP_ROR: return 8'h83;
      OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC:         return 8'h82;
      default:                                        return 8'h00;
    endcase
  endfunction

  state_t             r_state;
  state_t             w_next;
  op_t                r_op;
  logic               r_dec;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic               r_v;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_alu_out;
  logic [7:0]         r_flags_out;
  logic [7:0]         r_flags_ena;

  logic               w_accept;
  logic               w_last;
  logic               w_msb_first;
  logic [CNT_W-1:0]   w_lane;
  logic [DATA_W-1:0]  w_a_lane;
  logic [DATA_W-1:0]  w_b_lane;
  logic [DATA_W-1:0]  w_bop;
  logic [DATA_W:0]    w_bin;
  logic [DATA_W-1:0]  w_dsum;
  logic [4:0]         w_nib;
  logic               w_nc;
  logic               w_dec_mode;
  logic [DATA_W-1:0]  w_lane_out;
  logic               w_lane_c;
  logic               w_v;
  logic [7:0]         w_mask;

  assign w_accept    = (r_state == S_IDLE) && start && !r_done;
  assign w_last      = (r_cnt == CNT_W'(LANES - 1));
  assign w_msb_first = (r_op == OP_LSR) || (r_op == OP_ROR);
  assign w_lane      = w_msb_first ? (CNT_W'(LANES - 1) - r_cnt) : r_cnt;
  assign w_a_lane    = r_a[w_lane*DATA_W +: DATA_W];
  assign w_b_lane    = r_b[w_lane*DATA_W +: DATA_W];
  assign w_dec_mode  = r_dec && DEC_EN && ((r_op == OP_ADC) || (r_op == OP_SBC));
  assign w_mask      = f_mask(r_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One lane of datapath; INC/DEC reuse the adder with a constant B operand.
  always_comb begin
    w_bop      = w_b_lane;
    w_bin      = '0;
    w_dsum     = '0;
    w_nib      = '0;
    w_nc       = r_carry;
    w_lane_out = '0;
    w_lane_c   = r_carry;
    w_v        = 1'b0;
    case (r_op)
      OP_SBC, OP_CMP: w_bop = ~w_b_lane;
      OP_INC:         w_bop = '0;
      OP_DEC:         w_bop = '1;
      default:        w_bop = w_b_lane;
    endcase
    w_bin = {1'b0, w_a_lane} + {1'b0, w_bop} + {{DATA_W{1'b0}}, r_carry};
    for (int unsigned i = 0; i < NIBS; i++) begin
      w_nib = {1'b0, w_a_lane[i*4 +: 4]} + {1'b0, w_bop[i*4 +: 4]} + {4'b0, w_nc};
      if (r_op == OP_SBC) begin
        w_nc = w_nib[4];
        if (!w_nc) w_nib = w_nib - 5'd6;
      end else if (w_nib > 5'd9) begin
        w_nib = w_nib + 5'd6;
        w_nc  = 1'b1;
      end else begin
        w_nc = 1'b0;
      end
      w_dsum[i*4 +: 4] = w_nib[3:0];
    end
    w_v = (w_a_lane[DATA_W-1] == w_bop[DATA_W-1]) && (w_bin[DATA_W-1] != w_a_lane[DATA_W-1]);
    case (r_op)
      OP_ADD, OP_ADC, OP_SBC, OP_CMP, OP_INC, OP_DEC: begin
        if (w_dec_mode) begin
          w_lane_out = w_dsum;
          w_lane_c   = w_nc;
        end else begin
          w_lane_out = w_bin[DATA_W-1:0];
          w_lane_c   = w_bin[DATA_W];
        end
      end
      OP_AND: w_lane_out = w_a_lane & w_b_lane;
      OP_ORA: w_lane_out = w_a_lane | w_b_lane;
      OP_EOR: w_lane_out = w_a_lane ^ w_b_lane;
      OP_ASL, OP_ROL: begin
        w_lane_out = {w_a_lane[DATA_W-2:0], r_carry};
        w_lane_c   = w_a_lane[DATA_W-1];
      end
      OP_LSR, OP_ROR: begin
        w_lane_out = {r_carry, w_a_lane[DATA_W-1:1]};
        w_lane_c   = w_a_lane[0];
      end
      default: w_lane_out = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= OP_ADD;
      r_dec       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_v         <= 1'b0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_alu_out   <= '0;
      r_flags_out <= '0;
      r_flags_ena <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= op_t'(op);
            r_dec   <= decimal;
            r_a     <= alu_a;
            r_b     <= alu_b;
            r_res   <= '0;
            r_carry <= f_init_carry(op_t'(op), carry_in);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_res[w_lane*DATA_W +: DATA_W] <= w_lane_out;
          r_carry <= w_lane_c;
          r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) r_v <= w_v;
        end
        S_DONE: begin
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_alu_out   <= r_res;
          r_flags_ena <= w_mask;
          r_flags_out <= {r_res[WIDTH-1] & w_mask[7], r_v & w_mask[6], 4'b0000,
                          (r_res == '0) & w_mask[1], r_carry & w_mask[0]};
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign alu_out   = r_alu_out;
  assign flags_out = r_flags_out;
  assign flags_ena = r_flags_ena;

endmodule

// File: tb/tb_alu_multilane.sv
// Self-checking bench for alu_multilane (DATA_W=8, LANES=2); BCD vectors follow ALU_MULTILANE_DECIMAL_EN.
module tb_alu_multilane;

  localparam int DW = 8;
  localparam int LN = 2;
  localparam int W  = DW * LN;
  localparam int ND = W / 4;
  localparam int LW = W - DW;
`ifdef ALU_MULTILANE_DECIMAL_EN
  localparam bit DEC_ON = 1'b1;
`else
  localparam bit DEC_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic         decimal;
  logic         carry_in;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         busy;
  logic         done;
  logic [W-1:0] alu_out;
  logic [7:0]   flags_out;
  logic [7:0]   flags_ena;

  int n_tests = 0;
  int n_fail  = 0;

  alu_multilane #(.DATA_W(DW), .LANES(LN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .decimal(decimal),
    .carry_in(carry_in), .alu_a(alu_a), .alu_b(alu_b), .busy(busy),
    .done(done), .alu_out(alu_out), .flags_out(flags_out), .flags_ena(flags_ena)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic         dec;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic [7:0]   flags;
    logic [7:0]   ena;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic longint bcd_val(input logic [W-1:0] x, input int nd);
    longint v = 0;
    for (int i = nd - 1; i >= 0; i--) v = v * 10 + longint'(x[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint n);
    logic [W-1:0] r = '0;
    longint m = n;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Whole-word reference: the result is computed on the full operand, not per lane.
  task automatic model(input logic [3:0] m_op, input logic m_dec, input logic m_cin,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [7:0] f, output logic [7:0] e);
    logic [W:0]    s;
    logic [W-1:0]  bp;
    logic          c, v, dm, ctop;
    logic [DW-1:0] at, bt;
    logic [DW:0]   tsum;
    longint        n, lo, cl, lim, lolim;
    r = '0; c = 1'b0; v = 1'b0; e = '0; bp = b; s = '0; ctop = 1'b0;
    cl    = longint'(m_cin);
    lim   = pow10(ND);
    lolim = pow10(LW / 4);
    dm    = DEC_ON && m_dec && (m_op == 4'd1 || m_op == 4'd2);
    case (m_op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; e = 8'h83; end
      4'd1, 4'd2: begin
        if (m_op == 4'd2) bp = ~b;
        e = 8'hC3;
        if (dm) begin
          if (m_op == 4'd1) begin
            n    = bcd_val(a, ND) + bcd_val(b, ND) + cl;
            c    = (n >= lim);
            r    = to_bcd(n % lim);
            lo   = bcd_val(a, LW / 4) + bcd_val(b, LW / 4) + cl;
            ctop = (lo >= lolim);
          end else begin
            n    = bcd_val(a, ND) - bcd_val(b, ND) - (1 - cl);
            c    = (n >= 0);
            r    = to_bcd((n < 0) ? n + lim : n);
            lo   = bcd_val(a, LW / 4) - bcd_val(b, LW / 4) - (1 - cl);
            ctop = (lo >= 0);
          end
        end else begin
          s    = {1'b0, a} + {1'b0, bp} + (W+1)'(m_cin);
          r    = s[W-1:0];
          c    = s[W];
          lo   = (longint'(a) % (longint'(1) << LW)) + (longint'(bp) % (longint'(1) << LW)) + cl;
          ctop = (lo >= (longint'(1) << LW));
        end
        at   = a[W-1 -: DW];
        bt   = bp[W-1 -: DW];
        tsum = {1'b0, at} + {1'b0, bt} + (DW+1)'(ctop);
        v    = (at[DW-1] == bt[DW-1]) && (tsum[DW-1] != at[DW-1]);
      end
      4'd3: begin bp = ~b; s = {1'b0, a} + {1'b0, bp} + 1; r = s[W-1:0]; c = s[W]; e = 8'h83; end
      4'd4: begin r = a & b; e = 8'h82; end
      4'd5: begin r = a | b; e = 8'h82; end
      4'd6: begin r = a ^ b; e = 8'h82; end
      4'd7: begin r = a << 1; c = a[W-1]; e = 8'h83; end
      4'd8: begin r = a >> 1; c = a[0]; e = 8'h83; end
      4'd9: begin r = {a[W-2:0], m_cin}; c = a[W-1]; e = 8'h83; end
      4'd10: begin r = {m_cin, a[W-1:1]}; c = a[0]; e = 8'h83; end
      4'd11: begin r = a + 1'b1; e = 8'h82; end
      4'd12: begin r = a - 1'b1; e = 8'h82; end
      default: begin r = '0; e = '0; end
    endcase
    f = {r[W-1] & e[7], v & e[6], 4'b0000, (r == '0) & e[1], c & e[0]};
  endtask

  task automatic run_op(input string name, input logic [3:0] f_op, input logic f_dec,
                        input logic f_cin, input logic [W-1:0] f_a, input logic [W-1:0] f_b,
                        input logic [W-1:0] x_out, input logic [7:0] x_flags, input logic [7:0] x_ena);
    int   cyc;
    logic seen;
    @(negedge clk);
    op = f_op; decimal = f_dec; carry_in = f_cin; alu_a = f_a; alu_b = f_b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " busy"}, 32'(busy), 32'd1);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    check({name, " latency"}, 32'(cyc), 32'(LN + 1));
    check({name, " out"}, 32'(alu_out), 32'(x_out));
    check({name, " flags"}, 32'(flags_out), 32'(x_flags));
    check({name, " ena"}, 32'(flags_ena), 32'(x_ena));
    check({name, " busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({name, " done_pulse"}, 32'(done), 32'd0);
    check({name, " held"}, 32'(alu_out), 32'(x_out));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         vecs[$];
    logic [3:0]   t_op;
    logic         t_dec, t_cin;
    logic [W-1:0] t_a, t_b, x_r;
    logic [7:0]   x_f, x_e;
    int           cyc, extra;
    logic         seen;

    vecs.push_back('{"adc_wrap_lane", 4'd1, 1'b0, 1'b0, 16'h12FF, 16'h0001, 16'h1300, 8'h00, 8'hC3});
    vecs.push_back('{"sbc_borrow",    4'd2, 1'b0, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 8'h80, 8'hC3});
    vecs.push_back('{"adc_overflow",  4'd1, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 8'hC0, 8'hC3});
    vecs.push_back('{"ror_cin",       4'd10, 1'b0, 1'b1, 16'h0001, 16'h0000, 16'h8000, 8'h81, 8'h83});
    vecs.push_back('{"lsr",           4'd8, 1'b0, 1'b0, 16'h8001, 16'h0000, 16'h4000, 8'h01, 8'h83});
    vecs.push_back('{"op14",          4'd14, 1'b0, 1'b1, 16'h1234, 16'h5678, 16'h0000, 8'h00, 8'h00});
    vecs.push_back('{"cmp_equal",     4'd3, 1'b0, 1'b0, 16'h1234, 16'h1234, 16'h0000, 8'h03, 8'h83});
    vecs.push_back('{"add_wrap",      4'd0, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 8'h03, 8'h83});
    vecs.push_back('{"inc_wrap",      4'd11, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 8'h02, 8'h82});
    vecs.push_back('{"dec_wrap",      4'd12, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 8'h80, 8'h82});
    vecs.push_back('{"asl",           4'd7, 1'b0, 1'b1, 16'h8001, 16'h0000, 16'h0002, 8'h01, 8'h83});
    vecs.push_back('{"rol_cin",       4'd9, 1'b0, 1'b1, 16'h8000, 16'h0000, 16'h0001, 8'h01, 8'h83});
    vecs.push_back('{"and",           4'd4, 1'b0, 1'b0, 16'hF0F0, 16'h0FF0, 16'h00F0, 8'h00, 8'h82});
    vecs.push_back('{"eor",           4'd6, 1'b0, 1'b0, 16'hFFFF, 16'h0F0F, 16'hF0F0, 8'h80, 8'h82});
    vecs.push_back('{"ora_zero",      4'd5, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 8'h02, 8'h82});
`ifdef ALU_MULTILANE_DECIMAL_EN
    vecs.push_back('{"dadc_0999",     4'd1, 1'b1, 1'b0, 16'h0999, 16'h0001, 16'h1000, 8'h00, 8'hC3});
    vecs.push_back('{"dadc_9999",     4'd1, 1'b1, 1'b0, 16'h9999, 16'h0001, 16'h0000, 8'h03, 8'hC3});
    vecs.push_back('{"dsbc_1000",     4'd2, 1'b1, 1'b1, 16'h1000, 16'h0001, 16'h0999, 8'h01, 8'hC3});
`else
    vecs.push_back('{"dadc_ignored",  4'd1, 1'b1, 1'b0, 16'h0999, 16'h0001, 16'h099A, 8'h00, 8'hC3});
`endif

    rst = 1'b1; start = 1'b0; op = '0; decimal = 1'b0; carry_in = 1'b0; alu_a = '0; alu_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset out", 32'(alu_out), 32'd0);
    check("reset flags", 32'(flags_out), 32'd0);
    check("reset ena", 32'(flags_ena), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].dec, vecs[i].cin, vecs[i].a, vecs[i].b,
             vecs[i].out, vecs[i].flags, vecs[i].ena);

    for (int k = 0; k < 150; k++) begin
      t_op  = 4'($urandom_range(0, 15));
      t_dec = 1'($urandom);
      t_cin = 1'($urandom);
      t_a   = W'($urandom);
      t_b   = W'($urandom);
      if (k % 10 == 0) t_a = '1;
      if (k % 10 == 5) t_b = '0;
      if (DEC_ON && t_dec && (t_op == 4'd1 || t_op == 4'd2)) begin
        t_a = to_bcd(longint'($urandom_range(0, 9999)));
        t_b = to_bcd(longint'($urandom_range(0, 9999)));
      end
      model(t_op, t_dec, t_cin, t_a, t_b, x_r, x_f, x_e);
      run_op($sformatf("rand%0d_op%0d", k, t_op), t_op, t_dec, t_cin, t_a, t_b, x_r, x_f, x_e);
    end

    // start held high through RUN, DONE and the done cycle: exactly one result
    @(negedge clk);
    op = 4'd0; decimal = 1'b0; carry_in = 1'b0; alu_a = 16'h0102; alu_b = 16'h0304; start = 1'b1;
    @(posedge clk); #1;
    op = 4'd4; alu_a = '0; alu_b = '0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    check("busy_start latency", 32'(cyc), 32'd3);
    check("busy_start out", 32'(alu_out), 32'h0406);
    @(posedge clk); #1;
    start = 1'b0;
    check("done_start busy", 32'(busy), 32'd0);
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check("no_second_done", 32'(extra), 32'd0);
    check("busy_start held", 32'(alu_out), 32'h0406);

    @(negedge clk);
    op = 4'd0; alu_a = 16'hFFFF; alu_b = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort out", 32'(alu_out), 32'd0);
    check("abort flags", 32'(flags_out), 32'd0);
    check("abort ena", 32'(flags_ena), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("abort no_done", 32'(extra), 32'd0);

    run_op("after_abort", 4'd0, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0002, 8'h00, 8'h83);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
